// File: rtl/cb_map_pkg.sv
// Shared select encodings, injection FSM states and lane-slice helper for the CB port-B router.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package cb_map_pkg;

    // Group field of CB_dinb_sel
    localparam logic [2:0] GRP_IDLE   = 3'b000;
    localparam logic [2:0] GRP_C      = 3'b001;
    localparam logic [2:0] GRP_XYXITA = 3'b101;
    localparam logic [2:0] GRP_LXLY   = 3'b110;

    // Direction field of CB_dinb_sel
    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_POS  = 2'b01;
    localparam logic [1:0] DIR_NEG  = 2'b10;
    localparam logic [1:0] DIR_NEW  = 2'b11;

    // Scalar injection sequencer states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_INJ  = 1'b1
    } inj_state_t;

    // Low bit position of a lane inside a flat lane vector
    function automatic int lane_lo(input int lane, input int dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/cb_lane_permute.sv
// Combinational X-lane to L-lane map for the POS, NEG and NEW directions, with lane mask.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is registered.
module cb_lane_permute
    import cb_map_pkg::*;
#(
    parameter int X       = 4,
    parameter int L       = 4,
    parameter int RSA_DW  = 32,
    parameter int SLOT_DW = 1
) (
    input  logic [1:0]          dir,
    input  logic [SLOT_DW-1:0]  slot,
    input  logic [X*RSA_DW-1:0] c_vec,
    output logic [L*RSA_DW-1:0] data,
    output logic [L-1:0]        mask,
    output logic                slot_err
);

    // Lanes that both sides actually have
    localparam int NPOS = (X < L) ? X : L;

    // Route source lanes to destination lanes; unused lanes stay zero with mask cleared
    always_comb begin : permute
        int lo;
        data     = '0;
        mask     = '0;
        slot_err = 1'b0;
        lo       = 2 * int'(slot);
        case (dir)
            DIR_POS: begin
                for (int j = 0; j < NPOS; j++) begin
                    data[lane_lo(j, RSA_DW) +: RSA_DW] = c_vec[lane_lo(j, RSA_DW) +: RSA_DW];
                    mask[j] = 1'b1;
                end
            end
            DIR_NEG: begin
                for (int j = 0; j < NPOS; j++) begin
                    data[lane_lo(L-1-j, RSA_DW) +: RSA_DW] = c_vec[lane_lo(j, RSA_DW) +: RSA_DW];
                    mask[L-1-j] = 1'b1;
                end
            end
            DIR_NEW: begin
                // A landmark pair needs both lanes of its slot to exist
                if (lo + 1 >= L) begin
                    slot_err = 1'b1;
                end else begin
                    data[lane_lo(lo, RSA_DW) +: RSA_DW]     = c_vec[0 +: RSA_DW];
                    data[lane_lo(lo + 1, RSA_DW) +: RSA_DW] = c_vec[RSA_DW +: RSA_DW];
                    mask[lo]     = 1'b1;
                    mask[lo + 1] = 1'b1;
                end
            end
            default: begin
                data = '0;
            end
        endcase
    end

endmodule

// File: rtl/cb_dinb_router.sv
// Registered router of RSA result vectors and sequenced robot/landmark scalars onto CB port-B lanes.
// Latency: 1 cycle from din_valid/inj_start to dout_valid; injection emits one beat per cycle.
// Backpressure: none downstream; while busy, inj_start is ignored and din_valid beats are dropped with err_sel.
module cb_dinb_router
    import cb_map_pkg::*;
#(
    parameter int X       = 4,
    parameter int L       = 4,
    parameter int RSA_DW  = 32,
    parameter int SEL_DW  = 5,
    parameter int SLOT_DW = 1
) (
    input  logic                clk,
    input  logic                sys_rst,
    input  logic [SEL_DW-1:0]   CB_dinb_sel,
    input  logic                din_valid,
    input  logic [X*RSA_DW-1:0] C_CB_dinb,
    input  logic [SLOT_DW-1:0]  lk_slot,
    input  logic                state_ld,
    input  logic [RSA_DW-1:0]   x_hat,
    input  logic [RSA_DW-1:0]   y_hat,
    input  logic [RSA_DW-1:0]   xita_hat,
    input  logic [RSA_DW-1:0]   lkx_hat,
    input  logic [RSA_DW-1:0]   lky_hat,
    input  logic                inj_start,
    output logic                busy,
    output logic [L*RSA_DW-1:0] CB_dinb,
    output logic                dout_valid,
    output logic [L-1:0]        dout_lane_mask,
    output logic                err_sel
);

    localparam int LW = (L > 1) ? $clog2(L) : 1;

    logic [2:0] grp;
    logic [1:0] dir;
    logic       lk_bad;

    assign grp    = 3'(CB_dinb_sel[SEL_DW-1:2]);
    assign dir    = CB_dinb_sel[1:0];
    assign lk_bad = (2 * int'(lk_slot) + 1) >= L;

    // Combinational lane map for C-group beats
    logic [L*RSA_DW-1:0] perm_data;
    logic [L-1:0]        perm_mask;
    logic                perm_slot_err;

    cb_lane_permute #(
        .X       (X),
        .L       (L),
        .RSA_DW  (RSA_DW),
        .SLOT_DW (SLOT_DW)
    ) u_permute (
        .dir      (dir),
        .slot     (lk_slot),
        .c_vec    (C_CB_dinb),
        .data     (perm_data),
        .mask     (perm_mask),
        .slot_err (perm_slot_err)
    );

    // Shadow state, injection snapshot and sequencer state
    logic [RSA_DW-1:0] sh_x, sh_y, sh_xita, sh_lkx, sh_lky;
    logic [RSA_DW-1:0] snap1, snap2;
    logic [LW-1:0]     inj_base;
    logic [1:0]        inj_last;
    inj_state_t        state, state_nx;
    logic [1:0]        cnt, cnt_nx;

    // Sequencer decode
    logic              start_xy, start_lk;
    logic              beat_vld;
    logic [LW-1:0]     beat_lane;
    logic [RSA_DW-1:0] beat_val;
    logic              c_take;
    logic              fsm_err;

    // Output assembly
    logic                dat_ld;
    logic [L*RSA_DW-1:0] dat_nx;
    logic                vld_nx;
    logic [L-1:0]        mask_nx;
    logic                c_err;

    assign busy = (state == ST_INJ);

    // Shadow registers follow state_ld every cycle, independent of the sequencer
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            sh_x    <= '0;
            sh_y    <= '0;
            sh_xita <= '0;
            sh_lkx  <= '0;
            sh_lky  <= '0;
        end else if (state_ld) begin
            sh_x    <= x_hat;
            sh_y    <= y_hat;
            sh_xita <= xita_hat;
            sh_lkx  <= lkx_hat;
            sh_lky  <= lky_hat;
        end
    end

    // Snapshot the remaining beats at start so later state_ld or sel changes cannot disturb them
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            snap1    <= '0;
            snap2    <= '0;
            inj_base <= '0;
            inj_last <= '0;
        end else if (start_xy) begin
            snap1    <= sh_y;
            snap2    <= sh_xita;
            inj_base <= '0;
            inj_last <= 2'd2;
        end else if (start_lk) begin
            snap1    <= sh_lky;
            snap2    <= '0;
            inj_base <= LW'(2 * int'(lk_slot));
            inj_last <= 2'd1;
        end
    end

    // Sequencer state and beat counter
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next state, beat selection and drop/illegal detection
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        start_xy  = 1'b0;
        start_lk  = 1'b0;
        beat_vld  = 1'b0;
        beat_lane = '0;
        beat_val  = '0;
        c_take    = 1'b0;
        fsm_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (inj_start) begin
                    // Injection wins over a same-cycle C beat
                    if (din_valid) fsm_err = 1'b1;
                    if (grp == GRP_XYXITA && L >= 3) begin
                        start_xy  = 1'b1;
                        beat_lane = '0;
                        beat_val  = sh_x;
                    end else if (grp == GRP_LXLY && !lk_bad) begin
                        start_lk  = 1'b1;
                        beat_lane = LW'(2 * int'(lk_slot));
                        beat_val  = sh_lkx;
                    end else begin
                        fsm_err = 1'b1;
                    end
                    if (start_xy || start_lk) begin
                        beat_vld = 1'b1;
                        state_nx = ST_INJ;
                        cnt_nx   = 2'd1;
                    end
                end else if (din_valid) begin
                    c_take = 1'b1;
                end
            end
            ST_INJ: begin
                if (din_valid) fsm_err = 1'b1;
                // One extra cycle after the last beat keeps busy aligned with dout_valid
                if (cnt > inj_last) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end else begin
                    beat_vld  = 1'b1;
                    beat_lane = inj_base + LW'(cnt);
                    beat_val  = (cnt == 2'd1) ? snap1 : snap2;
                    cnt_nx    = cnt + 2'd1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Build the next output beat from either an injection beat or a C-group beat
    always_comb begin
        dat_ld  = 1'b0;
        dat_nx  = '0;
        vld_nx  = 1'b0;
        mask_nx = '0;
        c_err   = 1'b0;
        if (beat_vld) begin
            dat_ld = 1'b1;
            dat_nx[lane_lo(int'(beat_lane), RSA_DW) +: RSA_DW] = beat_val;
            mask_nx[beat_lane] = 1'b1;
            vld_nx = 1'b1;
        end else if (c_take) begin
            // Every accepted C-path select rewrites the lanes, zeros when nothing legal is routed
            dat_ld = 1'b1;
            if (grp == GRP_C) begin
                if (perm_slot_err) begin
                    c_err = 1'b1;
                end else begin
                    dat_nx  = perm_data;
                    mask_nx = perm_mask;
                    vld_nx  = (dir != DIR_IDLE);
                end
            end else begin
                c_err = (grp != GRP_IDLE);
            end
        end
    end

    // Output registers; CB_dinb holds when no beat is taken
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            CB_dinb        <= '0;
            dout_valid     <= 1'b0;
            dout_lane_mask <= '0;
            err_sel        <= 1'b0;
        end else begin
            if (dat_ld) CB_dinb <= dat_nx;
            dout_valid     <= vld_nx;
            dout_lane_mask <= mask_nx;
            err_sel        <= fsm_err | c_err;
        end
    end

endmodule

// File: tb/tb_cb_dinb_router.sv
// Bench for cb_dinb_router with X=4, L=6, SLOT_DW=2: directed literal cases plus random traffic.
// Latency: outputs compared one cycle after the inputs that produced them.
// Backpressure: a queue of pending injection beats stands in for the busy window.
module tb_cb_dinb_router;

    localparam int X       = 4;
    localparam int L       = 6;
    localparam int DW      = 32;
    localparam int SEL_DW  = 5;
    localparam int SLOT_DW = 2;

    logic              clk = 1'b0;
    logic              sys_rst;
    logic [SEL_DW-1:0] CB_dinb_sel;
    logic              din_valid;
    logic [X*DW-1:0]   C_CB_dinb;
    logic [SLOT_DW-1:0] lk_slot;
    logic              state_ld;
    logic [DW-1:0]     x_hat, y_hat, xita_hat, lkx_hat, lky_hat;
    logic              inj_start;
    logic              busy;
    logic [L*DW-1:0]   CB_dinb;
    logic              dout_valid;
    logic [L-1:0]      dout_lane_mask;
    logic              err_sel;

    cb_dinb_router #(
        .X(X), .L(L), .RSA_DW(DW), .SEL_DW(SEL_DW), .SLOT_DW(SLOT_DW)
    ) dut (
        .clk            (clk),
        .sys_rst        (sys_rst),
        .CB_dinb_sel    (CB_dinb_sel),
        .din_valid      (din_valid),
        .C_CB_dinb      (C_CB_dinb),
        .lk_slot        (lk_slot),
        .state_ld       (state_ld),
        .x_hat          (x_hat),
        .y_hat          (y_hat),
        .xita_hat       (xita_hat),
        .lkx_hat        (lkx_hat),
        .lky_hat        (lky_hat),
        .inj_start      (inj_start),
        .busy           (busy),
        .CB_dinb        (CB_dinb),
        .dout_valid     (dout_valid),
        .dout_lane_mask (dout_lane_mask),
        .err_sel        (err_sel)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [L*DW-1:0] lanes6(input logic [31:0] l5, input logic [31:0] l4,
                                               input logic [31:0] l3, input logic [31:0] l2,
                                               input logic [31:0] l1, input logic [31:0] l0);
        return {l5, l4, l3, l2, l1, l0};
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [7:0]    lane;
        logic [DW-1:0] val;
    } beat_t;

    logic [DW-1:0] m_lane [L];
    logic [DW-1:0] m_sh   [5];
    logic          m_vld, m_err, m_busy;
    logic [L-1:0]  m_mask;
    beat_t         m_q [$];

    task automatic m_clear();
        for (int i = 0; i < L; i++) m_lane[i] = '0;
    endtask

    task automatic m_emit(input beat_t b);
        m_clear();
        m_lane[b.lane] = b.val;
        m_mask = '0;
        m_mask[b.lane] = 1'b1;
        m_vld = 1'b1;
    endtask

    task automatic model_step();
        logic [2:0]    g;
        logic [1:0]    d;
        int            s;
        logic [DW-1:0] c [X];
        for (int k = 0; k < X; k++) c[k] = C_CB_dinb[k*DW +: DW];
        g = CB_dinb_sel[4:2];
        d = CB_dinb_sel[1:0];
        s = int'(lk_slot);
        m_vld  = 1'b0;
        m_mask = '0;
        m_err  = 1'b0;
        if (m_busy) begin
            if (din_valid) m_err = 1'b1;
            if (m_q.size() > 0) m_emit(m_q.pop_front());
            else m_busy = 1'b0;
        end else if (inj_start) begin
            if (din_valid) m_err = 1'b1;
            if (g == 3'b101 && L >= 3) begin
                m_q.push_back({8'd0, m_sh[0]});
                m_q.push_back({8'd1, m_sh[1]});
                m_q.push_back({8'd2, m_sh[2]});
            end else if (g == 3'b110 && 2*s + 1 < L) begin
                m_q.push_back({8'(2*s), m_sh[3]});
                m_q.push_back({8'(2*s + 1), m_sh[4]});
            end else begin
                m_err = 1'b1;
            end
            if (m_q.size() > 0) begin
                m_busy = 1'b1;
                m_emit(m_q.pop_front());
            end
        end else if (din_valid) begin
            m_clear();
            if (g == 3'b001) begin
                if (d == 2'b01) begin
                    for (int i = 0; i < L; i++)
                        if (i < X) begin m_lane[i] = c[i]; m_mask[i] = 1'b1; end
                    m_vld = 1'b1;
                end else if (d == 2'b10) begin
                    for (int i = 0; i < L; i++)
                        if (L-1-i < X) begin m_lane[i] = c[L-1-i]; m_mask[i] = 1'b1; end
                    m_vld = 1'b1;
                end else if (d == 2'b11) begin
                    if (2*s + 1 >= L) m_err = 1'b1;
                    else begin
                        m_lane[2*s] = c[0];
                        m_lane[2*s+1] = c[1];
                        m_mask[2*s] = 1'b1;
                        m_mask[2*s+1] = 1'b1;
                        m_vld = 1'b1;
                    end
                end
            end else if (g != 3'b000) begin
                m_err = 1'b1;
            end
        end
        if (state_ld) begin
            m_sh[0] = x_hat; m_sh[1] = y_hat; m_sh[2] = xita_hat;
            m_sh[3] = lkx_hat; m_sh[4] = lky_hat;
        end
    endtask

    // Model advances on the same edge the DUT samples its inputs
    always @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            m_clear();
            for (int k = 0; k < 5; k++) m_sh[k] = '0;
            m_vld = 1'b0; m_err = 1'b0; m_busy = 1'b0; m_mask = '0;
            m_q.delete();
        end else begin
            model_step();
        end
    end

    // Compare every cycle on the falling edge
    always @(negedge clk) begin : cmp
        logic [L*DW-1:0] e;
        if (sys_rst === 1'b0) begin
            for (int i = 0; i < L; i++) e[i*DW +: DW] = m_lane[i];
            chk("CB_dinb",    256'(CB_dinb), 256'(e));
            chk("dout_valid", 256'(dout_valid), 256'(m_vld));
            chk("lane_mask",  256'(dout_lane_mask), 256'(m_mask));
            chk("err_sel",    256'(err_sel), 256'(m_err));
            chk("busy",       256'(busy), 256'(m_busy));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        din_valid = 1'b0; inj_start = 1'b0; state_ld = 1'b0;
    endtask

    initial begin
        sys_rst = 1'b1;
        CB_dinb_sel = '0; C_CB_dinb = '0; lk_slot = '0;
        x_hat = '0; y_hat = '0; xita_hat = '0; lkx_hat = '0; lky_hat = '0;
        idle_in();
        repeat (2) tick();
        chk("rst_dinb",  256'(CB_dinb), 256'(0));
        chk("rst_valid", 256'(dout_valid), 256'(0));
        chk("rst_busy",  256'(busy), 256'(0));
        sys_rst = 1'b0;
        tick();

        // POS
        C_CB_dinb = {32'd4, 32'd3, 32'd2, 32'd1};
        CB_dinb_sel = 5'b00101; din_valid = 1'b1;
        tick();
        chk("pos_lanes", 256'(CB_dinb), 256'(lanes6(0, 0, 4, 3, 2, 1)));
        chk("pos_mask",  256'(dout_lane_mask), 256'(6'b001111));
        chk("pos_valid", 256'(dout_valid), 256'(1));

        // NEG
        CB_dinb_sel = 5'b00110;
        tick();
        chk("neg_lanes", 256'(CB_dinb), 256'(lanes6(1, 2, 3, 4, 0, 0)));
        chk("neg_mask",  256'(dout_lane_mask), 256'(6'b111100));

        // Hold with din_valid low
        din_valid = 1'b0;
        tick();
        chk("hold_lanes", 256'(CB_dinb), 256'(lanes6(1, 2, 3, 4, 0, 0)));
        chk("hold_valid", 256'(dout_valid), 256'(0));

        // NEW at slot 2
        C_CB_dinb = {32'd0, 32'd0, 32'd9, 32'd7};
        CB_dinb_sel = 5'b00111; lk_slot = 2'd2; din_valid = 1'b1;
        tick();
        chk("new_lanes", 256'(CB_dinb), 256'(lanes6(9, 7, 0, 0, 0, 0)));
        chk("new_mask",  256'(dout_lane_mask), 256'(6'b110000));

        // NEW at slot 3 does not fit in 6 lanes
        lk_slot = 2'd3;
        tick();
        chk("newbad_err",   256'(err_sel), 256'(1));
        chk("newbad_valid", 256'(dout_valid), 256'(0));
        chk("newbad_lanes", 256'(CB_dinb), 256'(0));

        // Undefined group
        C_CB_dinb = {32'd4, 32'd3, 32'd2, 32'd1};
        CB_dinb_sel = 5'b01001;
        tick();
        chk("illegal_err",   256'(err_sel), 256'(1));
        chk("illegal_valid", 256'(dout_valid), 256'(0));
        chk("illegal_lanes", 256'(CB_dinb), 256'(0));

        // XYXITA injection, with drops while busy
        din_valid = 1'b0; state_ld = 1'b1;
        x_hat = 32'd10; y_hat = 32'd20; xita_hat = 32'd30; lkx_hat = 32'd5; lky_hat = 32'd6;
        tick();
        state_ld = 1'b0; inj_start = 1'b1; CB_dinb_sel = 5'b10100;
        tick();
        chk("xy0_lanes", 256'(CB_dinb), 256'(lanes6(0, 0, 0, 0, 0, 10)));
        chk("xy0_mask",  256'(dout_lane_mask), 256'(6'b000001));
        chk("xy0_busy",  256'(busy), 256'(1));
        CB_dinb_sel = 5'b11000; lk_slot = 2'd1; din_valid = 1'b1;
        tick();
        chk("xy1_lanes", 256'(CB_dinb), 256'(lanes6(0, 0, 0, 0, 20, 0)));
        chk("xy1_mask",  256'(dout_lane_mask), 256'(6'b000010));
        chk("xy1_err",   256'(err_sel), 256'(1));
        tick();
        chk("xy2_lanes", 256'(CB_dinb), 256'(lanes6(0, 0, 0, 30, 0, 0)));
        chk("xy2_mask",  256'(dout_lane_mask), 256'(6'b000100));
        tick();
        chk("xyend_busy",  256'(busy), 256'(0));
        chk("xyend_valid", 256'(dout_valid), 256'(0));
        chk("xyend_err",   256'(err_sel), 256'(1));
        din_valid = 1'b0;
        tick();
        chk("lk0_lanes", 256'(CB_dinb), 256'(lanes6(0, 0, 0, 5, 0, 0)));
        chk("lk0_err",   256'(err_sel), 256'(0));
        inj_start = 1'b0;
        tick();
        chk("lk1_lanes", 256'(CB_dinb), 256'(lanes6(0, 0, 6, 0, 0, 0)));
        chk("lk1_mask",  256'(dout_lane_mask), 256'(6'b001000));
        tick();
        chk("lkend_busy", 256'(busy), 256'(0));

        // Same-cycle inj_start and din_valid
        inj_start = 1'b1; CB_dinb_sel = 5'b10100; din_valid = 1'b1;
        tick();
        chk("both_err",   256'(err_sel), 256'(1));
        chk("both_lanes", 256'(CB_dinb), 256'(lanes6(0, 0, 0, 0, 0, 10)));
        idle_in();
        repeat (3) tick();

        // Asynchronous reset mid-injection
        inj_start = 1'b1;
        tick();
        inj_start = 1'b0;
        #1 sys_rst = 1'b1;
        #1;
        chk("arst_lanes", 256'(CB_dinb), 256'(0));
        chk("arst_valid", 256'(dout_valid), 256'(0));
        chk("arst_busy",  256'(busy), 256'(0));
        #1 sys_rst = 1'b0;
        tick();
        chk("arst_after_valid", 256'(dout_valid), 256'(0));
        C_CB_dinb = {32'd4, 32'd3, 32'd2, 32'd1};
        CB_dinb_sel = 5'b00101; din_valid = 1'b1;
        tick();
        chk("arst_pos", 256'(CB_dinb), 256'(lanes6(0, 0, 4, 3, 2, 1)));
        idle_in();
        tick();

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 4)      CB_dinb_sel = {3'b001, 2'($urandom_range(0, 3))};
            else if (r == 5) CB_dinb_sel = {3'b101, 2'($urandom_range(0, 3))};
            else if (r == 6) CB_dinb_sel = {3'b110, 2'($urandom_range(0, 3))};
            else if (r == 7) CB_dinb_sel = {3'b000, 2'($urandom_range(0, 3))};
            else             CB_dinb_sel = 5'($urandom_range(0, 31));
            din_valid = 1'($urandom_range(0, 1));
            inj_start = ($urandom_range(0, 7) == 0);
            state_ld  = ($urandom_range(0, 3) == 0);
            lk_slot   = 2'($urandom_range(0, 3));
            x_hat = $urandom(); y_hat = $urandom(); xita_hat = $urandom();
            lkx_hat = $urandom(); lky_hat = $urandom();
            for (int k = 0; k < X; k++) C_CB_dinb[k*DW +: DW] = $urandom();
            tick();
        end
        idle_in();
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
